// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a small input FIFO.
// Words are accepted on a ready/valid handshake, queued, and sent as
// start / data (LSB first) / optional parity / stop frames, back-to-back
// while the queue is non-empty.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
  localparam int BIT_W  = $clog2(DATA_BITS);

  // Mode 3 is folded into "no parity".
  localparam bit PAR_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit PAR_ODD = (PARITY_MODE == 1);

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [2:0]           r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;

  logic                 r_tx_out;
  logic                 r_tx_busy;
  logic                 r_tx_done;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_stop_end;
  logic                 w_line;

  // NOTE: ready comes only from the registered count, so a pop on the same
  // edge never frees a slot early and there is no path from tx_valid.
  assign tx_ready   = (r_count != FULL_CNT);
  assign w_push     = tx_valid && tx_ready;
  assign w_bit_end  = (r_baud == BIT_LAST);
  assign w_stop_end = (r_state == S_STOP) && (r_baud == STOP_LAST);
  assign w_pop      = (r_count != '0) && ((r_state == S_IDLE) || w_stop_end);

  assign tx_out     = r_tx_out;
  assign tx_busy    = r_tx_busy;
  assign tx_done    = r_tx_done;
  assign fifo_count = r_count;

  // FIFO storage write.
  // NOTE: the storage array has no reset; only pointers and count carry
  // validity, so clearing them is enough to discard queued words.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // Freeze the popped word and its parity for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_pop) begin
      r_shift  <= r_mem[r_rd_ptr];
      r_parity <= PAR_ODD ^ (^r_mem[r_rd_ptr]);
    end else if ((r_state == S_DATA) && w_bit_end && (r_bit_idx != DATA_LAST)) begin
      r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
    end
  end

  // Frame sequencer: state, baud counter and data-bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) r_state <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == DATA_LAST) r_state <= PAR_EN ? S_PARITY : S_STOP;
            else                        r_bit_idx <= r_bit_idx + BIT_W'(1);
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_stop_end) begin
            r_baud  <= '0;
            r_state <= w_pop ? S_START : S_IDLE;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_baud  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Line level implied by the current sequencer state.
  // NOTE: default assignment first so no path leaves w_line unassigned (no latch).
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
      S_PARITY: w_line = r_parity;
      default:  w_line = 1'b1;
    endcase
  end

  // Registered outputs so the pin never sees decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_out  <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_out  <= w_line;
      r_tx_busy <= (r_state != S_IDLE);
      r_tx_done <= w_stop_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2, 4 clocks/bit)
// checked every cycle against a frame-level model, plus literal expectations.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic [7:0] d0 = '0;
  logic [6:0] d1 = '0;
  logic [6:0] d2 = '0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       r0, r1, r2;
  logic       o0, o1, o2;
  logic       b0, b1, b2;
  logic       n0, n1, n2;
  logic [2:0] c0, c1, c2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(r0),
    .tx_out(o0), .tx_busy(b0), .tx_done(n0), .fifo_count(c0));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1),
    .tx_out(o1), .tx_busy(b1), .tx_done(n1), .fifo_count(c1));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2), .tx_ready(r2),
    .tx_out(o2), .tx_busy(b2), .tx_done(n2), .fifo_count(c2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int p_db(input int i); return (i == 0) ? 8 : 7; endfunction
  function automatic int p_pm(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int p_sb(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int p_fl(input int i);
    return (1 + p_db(i) + ((p_pm(i) != 0) ? 1 : 0) + p_sb(i)) * CPB;
  endfunction

  // Level of serial bit slot b of the frame carrying word w.
  function automatic logic frame_bit(input int i, input int w, input int b);
    int ones;
    if (b == 0) return 1'b0;
    if (b <= p_db(i)) return logic'((w >> (b - 1)) & 1);
    if ((p_pm(i) != 0) && (b == p_db(i) + 1)) begin
      ones = $countones(w);
      return (p_pm(i) == 2) ? logic'(ones % 2) : logic'(1 - (ones % 2));
    end
    return 1'b1;
  endfunction

  int   m_fifo [3][DEPTH];
  int   m_size [3];
  bit   m_act  [3];
  int   m_pos  [3];
  int   m_word [3];
  logic m_out  [3];
  logic m_busy [3];
  logic m_done [3];

  task automatic model_reset(input int i);
    m_size[i] = 0; m_act[i] = 0; m_pos[i] = 0; m_word[i] = 0;
    m_out[i] = 1'b1; m_busy[i] = 1'b0; m_done[i] = 1'b0;
  endtask

  // Advance one clock edge with the inputs presented to that edge.
  task automatic model_step(input int i, input logic valid, input int data);
    int size_before;
    size_before = m_size[i];
    if (m_act[i]) begin
      m_out[i]  = frame_bit(i, m_word[i], m_pos[i] / CPB);
      m_busy[i] = 1'b1;
      m_done[i] = (m_pos[i] == p_fl(i) - 1);
    end else begin
      m_out[i] = 1'b1; m_busy[i] = 1'b0; m_done[i] = 1'b0;
    end
    if ((m_size[i] > 0) && (!m_act[i] || (m_pos[i] == p_fl(i) - 1))) begin
      m_word[i] = m_fifo[i][0];
      for (int k = 0; k < DEPTH - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
      m_size[i]--;
      m_act[i] = 1;
      m_pos[i] = 0;
    end else if (m_act[i]) begin
      if (m_pos[i] == p_fl(i) - 1) m_act[i] = 0;
      else                         m_pos[i]++;
    end
    if (valid && (size_before != DEPTH)) begin
      m_fifo[i][m_size[i]] = data;
      m_size[i]++;
    end
  endtask

  task automatic model_cmp(input int i, input logic out, input logic busy, input logic done,
                           input logic ready, input logic [2:0] cnt);
    check($sformatf("u%0d tx_out @%0d", i, cyc), {31'b0, out}, {31'b0, m_out[i]});
    check($sformatf("u%0d tx_busy @%0d", i, cyc), {31'b0, busy}, {31'b0, m_busy[i]});
    check($sformatf("u%0d tx_done @%0d", i, cyc), {31'b0, done}, {31'b0, m_done[i]});
    check($sformatf("u%0d tx_ready @%0d", i, cyc), {31'b0, ready}, (m_size[i] != DEPTH) ? 32'd1 : 32'd0);
    check($sformatf("u%0d fifo_count @%0d", i, cyc), {29'b0, cnt}, 32'(m_size[i]));
  endtask

  // Compare process: every cycle, mid-cycle, then advance with next-edge inputs.
  always @(negedge clk) begin
    if (!rst_n) for (int i = 0; i < 3; i++) model_reset(i);
    model_cmp(0, o0, b0, n0, r0, c0);
    model_cmp(1, o1, b1, n1, r1, c1);
    model_cmp(2, o2, b2, n2, r2, c2);
    if (rst_n) begin
      model_step(0, v0, int'(d0));
      model_step(1, v1, int'(d1));
      model_step(2, v2, int'(d2));
    end
  end

  // Wait until all instances are idle and empty; ends just after a rising edge.
  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = !b0 && !b1 && !b2 && (c0 == 0) && (c1 == 0) && (c2 == 0);
    end
    check({name, " drain timeout"}, {31'b0, ok}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  first_low, busy_cnt, done_cnt, done_c, busy1_cnt, busy2_cnt;
    int  par1, par2, idle_cnt;
    logic [9:0] line;
    int  acc_edge [6];
    bit  got;

    for (int i = 0; i < 3; i++) model_reset(i);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    check("reset tx_out", {31'b0, o0}, 32'd1);
    check("reset tx_busy", {31'b0, b0}, 32'd0);
    check("reset tx_done", {31'b0, n0}, 32'd0);
    check("reset fifo_count", {29'b0, c0}, 32'd0);
    check("reset tx_ready", {31'b0, r0}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---- single frames: 0xA5 on 8N1, 0x53 on 7E2 and 7O2 ----
    v0 = 1'b1; d0 = 8'hA5; v1 = 1'b1; d1 = 7'h53; v2 = 1'b1; d2 = 7'h53;
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    first_low = -1; busy_cnt = 0; done_cnt = 0; done_c = -1;
    busy1_cnt = 0; busy2_cnt = 0; par1 = -1; par2 = -1; line = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!o0 && first_low < 0) first_low = c;
      if (b0) busy_cnt++;
      if (b1) busy1_cnt++;
      if (b2) busy2_cnt++;
      if (n0) begin done_cnt++; done_c = c; end
      for (int b = 0; b < 10; b++) if (c == 2 + 4 * b + 1) line[b] = o0;
      if (c == 2 + 4 * 8 + 1) begin par1 = int'(o1); par2 = int'(o2); end
    end
    check("A5 first low cycle", 32'(first_low), 32'd2);
    check("A5 line bits", {22'b0, line}, 32'h34A);
    check("A5 busy cycles", 32'(busy_cnt), 32'd40);
    check("A5 done pulses", 32'(done_cnt), 32'd1);
    check("A5 done cycle", 32'(done_c), 32'd41);
    check("53 even parity", 32'(par1), 32'd0);
    check("53 odd parity", 32'(par2), 32'd1);
    check("7E2 busy cycles", 32'(busy1_cnt), 32'd44);
    check("7O2 busy cycles", 32'(busy2_cnt), 32'd44);
    wait_idle("single");

    // ---- hold valid with 0x01..0x06 on 8N1 ----
    for (int w = 0; w < 6; w++) begin
      d0 = 8'(w + 1); v0 = 1'b1;
      got = 0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        if (w == 5 && t == 0) begin
          check("full tx_ready", {31'b0, r0}, 32'd0);
          check("full fifo_count", {29'b0, c0}, 32'd4);
        end
        got = r0;
        @(posedge clk);
        #1;
      end
      acc_edge[w] = cyc;
      check($sformatf("word %0d accepted", w + 1), {31'b0, got}, 32'd1);
    end
    v0 = 1'b0;
    for (int w = 1; w < 5; w++)
      check($sformatf("word %0d accept offset", w + 1), 32'(acc_edge[w] - acc_edge[0]), 32'(w));
    check("word 6 accept offset", 32'(acc_edge[5] - acc_edge[0]), 32'd42);
    wait_idle("burst");

    // ---- push on the edge the FSM pops the last queued word ----
    v0 = 1'b1; d0 = 8'h3C;
    @(posedge clk);
    #1 d0 = 8'hC3;
    @(posedge clk);
    #1 v0 = 1'b0;
    @(negedge clk);
    check("push+pop fifo_count", {29'b0, c0}, 32'd1);
    wait_idle("pushpop");

    // ---- reset in the middle of DATA with 3 words queued ----
    v0 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      d0 = 8'(8'h11 * (w + 1));
      @(posedge clk);
      #1;
    end
    v0 = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midframe reset tx_out", {31'b0, o0}, 32'd1);
    check("midframe reset fifo_count", {29'b0, c0}, 32'd0);
    check("midframe reset tx_busy", {31'b0, b0}, 32'd0);
    check("midframe reset tx_done", {31'b0, n0}, 32'd0);
    check("midframe reset tx_ready", {31'b0, r0}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (o0 && !b0 && !n0) idle_cnt++;
    end
    check("post-reset idle cycles", 32'(idle_cnt), 32'd60);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter and successor to the team's fixed 8N1 transmitter.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- A ready/valid input handshake backed by a small FIFO, so the mining core can queue result/nonce bytes without waiting for each frame to finish.
- Sits between the result formatter and the board TX pin; frames go out back-to-back with no idle gap while data is queued.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per serial bit (50 MHz / 9600 baud). Legal range ≥ 2.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even. 3 is illegal and treated as 0.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: queue depth in words. Power of 2, ≥ 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- tx_data, input, DATA_BITS: word to transmit.
- tx_valid, input, 1: tx_data is valid this cycle.
- tx_ready, output, 1: FIFO can accept a word this cycle.
- tx_out, output, 1: serial line, idle high.
- tx_busy, output, 1: high while a frame is on the line.
- tx_done, output, 1: one-cycle pulse at the end of each frame.
- fifo_count, output, clog2(FIFO_DEPTH)+1: words currently queued.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx_out=1, tx_busy=0, tx_done=0, fifo_count=0.
  - FIFO pointers cleared; FSM forced to IDLE; all counters cleared.
  - tx_ready=1 while in reset, because it is decoded from the empty count.
- Reset asserted mid-frame: line returns high immediately, the frame is abandoned, queued words are discarded and no tx_done is issued.
- Handshake:
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered state only. It has no path from tx_valid.
  - A word is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data may change freely when not accepted.
  - No bypass: when full, tx_ready is low even if a pop occurs in the same cycle.
- FIFO:
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Words are transmitted in acceptance order.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1, tx_busy=0. If the FIFO is non-empty, pop the head into a shift register, compute parity and go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles. After the last bit go to PARITY if PARITY_MODE≠0, otherwise STOP.
  - PARITY: one bit, CLKS_PER_BIT cycles.
    - Even mode: XOR of the data bits.
    - Odd mode: its inverse, so the total count of ones is odd.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle, tx_done=1 for exactly one cycle. If the FIFO is non-empty on that same edge, pop and go straight to START (zero idle cycles); otherwise go to IDLE.
- Latency: a word accepted at edge E into an empty FIFO with the FSM in IDLE drives tx_out low from edge E+2 (one edge for the FIFO write, one for the IDLE pop).
- Frame length: (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_busy is high from the first START cycle through the last STOP cycle. It stays high continuously across back-to-back frames.
- tx_out, tx_busy and tx_done are registered outputs, with no combinational glitch on the line.
- Baud counter: width clog2(STOP_BITS*CLKS_PER_BIT)+1. Counts 0..N-1 and clears at each bit boundary.
- The sampled word is frozen in the shift register; FIFO activity during a frame does not affect it.

Test Plan:
- CLKS_PER_BIT=4, 8N1, push 0xA5 once → after 2 cycles, line is 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles wide. tx_done pulses once at cycle 40 of the frame; tx_busy is high for exactly 40 cycles.
- PARITY_MODE=2 then 1, DATA_BITS=7, push 0x53 (four ones) → parity bit 0 (even) / 1 (odd). STOP_BITS=2 gives a 44-cycle frame.
- FIFO_DEPTH=4, hold tx_valid high with 0x01..0x06 → first 5 words accepted (one pops immediately), tx_ready deasserts. All frames are sent back-to-back with no idle cycle between stop and next start, in order 0x01..0x05. 0x06 is accepted when space frees.
- With fifo_count=FIFO_DEPTH and a pop on the same edge as tx_valid → word not accepted that cycle; accepted the next cycle. fifo_count never exceeds FIFO_DEPTH.
- Assert rst_n low in the middle of DATA with 3 words queued → tx_out=1 asynchronously, fifo_count=0, no tx_done. After release the line stays idle until a new push.
- Push on the same edge the FSM pops the last queued word → fifo_count unchanged, both words transmitted in order.
